if_rf_pipe_ctrl: RTL

- RF-side end of the fetch/decode interface. Registers the decoded branch and register fields from the fetch stage.
- Resolves branch redirects and returns them to the PC incrementor as PCRF, BrTakenRF, UncondBrRF, CondAddr19RF and BrAddr26RF.
- Detects load-use hazards and stalls fetch while inserting a bubble toward EX.
- Sits between the IF stage and the register-file/EX stages of the five-stage LEGv8 pipeline.

---
 rtl/lr_pipe_pkg.sv | 33 +++
 rtl/hazard_detect.sv | 23 ++
 rtl/if_rf_pipe_ctrl.sv | 128 ++++++++++++
 3 files changed

// File: rtl/lr_pipe_pkg.sv
// Shared types and widths for the LEGv8 IF/RF pipeline control slice.
package lr_pipe_pkg;

    localparam int unsigned PC_W   = 64;
    localparam int unsigned COND_W = 19;
    localparam int unsigned BR_W   = 26;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = 2;

    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } pipe_state_t;

    // Decoded fields handed from IF to the RF stage.
    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic              uncond_br;
        logic              br_taken;
        logic [COND_W-1:0] cond_addr19;
        logic [BR_W-1:0]   br_addr26;
        logic [REG_W-1:0]  rn;
        logic [REG_W-1:0]  rm;
        logic              uses_rm;
    } rf_fields_t;

    function automatic logic reg_dep(input logic [REG_W-1:0] src, input logic [REG_W-1:0] dst);
        return (src == dst);
    endfunction

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard between the RF-stage sources and the EX-stage load destination.
module hazard_detect
    import lr_pipe_pkg::*;
(
    input  logic             i_rf_valid,
    input  logic             i_ex_load,
    input  logic [REG_W-1:0] i_ex_rd,
    input  logic [REG_W-1:0] i_rn,
    input  logic [REG_W-1:0] i_rm,
    input  logic             i_uses_rm,
    output logic             o_hazard_c
);

    logic w_rn_dep;
    logic w_rm_dep;

    assign w_rn_dep = reg_dep(i_rn, i_ex_rd);
    assign w_rm_dep = i_uses_rm & reg_dep(i_rm, i_ex_rd);

    // XZR is never really written, so a load to it cannot create a dependency.
    assign o_hazard_c = i_rf_valid & i_ex_load & (i_ex_rd != XZR) & (w_rn_dep | w_rm_dep);

endmodule

// File: rtl/if_rf_pipe_ctrl.sv
// RF-side end of the fetch/decode interface: registers IF fields, resolves
// branch redirects and stalls fetch on load-use hazards.
module if_rf_pipe_ctrl
    import lr_pipe_pkg::*;
#(
    parameter bit          DELAY_SLOT   = 1'b1,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [PC_W-1:0]   if_pc,
    input  logic              if_UncondBr,
    input  logic              if_BrTaken,
    input  logic [COND_W-1:0] if_CondAddr19,
    input  logic [BR_W-1:0]   if_BrAddr26,
    input  logic [REG_W-1:0]  if_Rn,
    input  logic [REG_W-1:0]  if_Rm,
    input  logic              if_usesRm,
    input  logic              ex_load,
    input  logic [REG_W-1:0]  ex_Rd,
    output logic [PC_W-1:0]   PCRF,
    output logic              BrTakenRF,
    output logic              UncondBrRF,
    output logic [COND_W-1:0] CondAddr19RF,
    output logic [BR_W-1:0]   BrAddr26RF,
    output logic [REG_W-1:0]  Rn_rf,
    output logic [REG_W-1:0]  Rm_rf,
    output logic              rf_valid,
    output logic              ex_valid,
    output logic              pc_hold
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STALL_CYCLES - 1);

    rf_fields_t        r_fields;
    rf_fields_t        w_if_fields;
    logic              r_rf_valid;
    pipe_state_t       r_state;
    pipe_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic              w_hazard;
    logic              w_pc_hold;
    logic              w_br_taken;
    logic              w_squash;

    assign w_if_fields = '{
        pc:          if_pc,
        uncond_br:   if_UncondBr,
        br_taken:    if_BrTaken,
        cond_addr19: if_CondAddr19,
        br_addr26:   if_BrAddr26,
        rn:          if_Rn,
        rm:          if_Rm,
        uses_rm:     if_usesRm
    };

    hazard_detect u_hazard_detect (
        .i_rf_valid (r_rf_valid),
        .i_ex_load  (ex_load),
        .i_ex_rd    (ex_Rd),
        .i_rn       (r_fields.rn),
        .i_rm       (r_fields.rm),
        .i_uses_rm  (r_fields.uses_rm),
        .o_hazard_c (w_hazard)
    );

    // Redirect fires only as the branch leaves RF, so a stalled branch waits.
    assign w_br_taken = r_rf_valid & r_fields.br_taken & ~w_pc_hold;
    assign w_squash   = w_br_taken & ~DELAY_SLOT;

    // RF register bank; frozen while fetch is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fields   <= '0;
            r_rf_valid <= 1'b0;
        end else if (!w_pc_hold) begin
            r_fields   <= w_if_fields;
            r_rf_valid <= ~w_squash;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= RUN;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Hazard is sampled only in RUN so one hazard costs exactly STALL_CYCLES bubbles.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pc_hold   = 1'b0;
        case (r_state)
            RUN: begin
                if (w_hazard) begin
                    w_state_nxt = STALL;
                    w_cnt_nxt   = CNT_LOAD;
                    w_pc_hold   = 1'b1;
                end
            end
            STALL: begin
                if (r_cnt == '0) begin
                    w_state_nxt = RUN;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    w_pc_hold = 1'b1;
                end
            end
        endcase
    end

    assign PCRF         = r_fields.pc;
    assign UncondBrRF   = r_fields.uncond_br;
    assign CondAddr19RF = r_fields.cond_addr19;
    assign BrAddr26RF   = r_fields.br_addr26;
    assign Rn_rf        = r_fields.rn;
    assign Rm_rf        = r_fields.rm;
    assign rf_valid     = r_rf_valid;
    assign BrTakenRF    = w_br_taken;
    assign pc_hold      = w_pc_hold;
    assign ex_valid     = r_rf_valid & ~w_pc_hold;

endmodule
